// File: rtl/greenflow_pkg.sv
// Shared definitions for the GreenFlow charger power scheduler: status codes,
// FSM state encoding and the default kW width.
package greenflow_pkg;

  localparam int KW_W_DEFAULT = 16;

  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_CLAMP   = 2'b01;
  localparam logic [1:0] STAT_THERMAL = 2'b10;
  localparam logic [1:0] STAT_OFF     = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SNAP   = 3'd2,
    ST_ALLOC  = 3'd3,
    ST_COMMIT = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

endpackage

// File: rtl/greenflow_alloc_step.sv
// One allocation step: grant min(req, budget) to a valid port and report the
// remaining budget and whether the request was cut short.
module greenflow_alloc_step
  import greenflow_pkg::*;
#(
  parameter int KW_W = KW_W_DEFAULT
) (
  input  logic            valid,
  input  logic [KW_W-1:0] req,
  input  logic [KW_W-1:0] budget,
  output logic [KW_W-1:0] grant,
  output logic [KW_W-1:0] budget_next,
  output logic            clamped
);

  // min/subtract; grant never exceeds budget so budget_next cannot underflow
  always_comb begin
    if (!valid) begin
      grant = '0;
    end else if (req <= budget) begin
      grant = req;
    end else begin
      grant = budget;
    end
    budget_next = budget - grant;
    clamped     = valid && (grant < req);
  end

endmodule

// File: rtl/greenflow_power_scheduler.sv
// Epoch-based round-robin grid budget scheduler for NUM_PORTS chargers, with
// thermal shutdown and enable gating.
module greenflow_power_scheduler
  import greenflow_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int KW_W         = KW_W_DEFAULT,
  parameter int EPOCH_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [KW_W-1:0]           grid_limit_kw,
  input  logic                      thermal_fault,
  input  logic [NUM_PORTS-1:0]      req_valid,
  input  logic [NUM_PORTS*KW_W-1:0] req_kw,
  output logic [NUM_PORTS*KW_W-1:0] grant_kw,
  output logic                      grant_update,
  output logic [KW_W-1:0]           budget_left_kw,
  output logic [1:0]                status_code
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW = $clog2(EPOCH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(EPOCH_CYCLES - 1);
  localparam logic [PW-1:0] PORT_LAST = PW'(NUM_PORTS - 1);
  localparam logic [PW:0]   PORT_NUM  = (PW + 1)'(NUM_PORTS);

  state_t                    state_r;
  logic [CW-1:0]             cnt_r;
  logic [PW-1:0]             rr_ptr_r;
  logic [PW-1:0]             idx_r;
  logic [NUM_PORTS-1:0]      snap_valid_r;
  logic [NUM_PORTS*KW_W-1:0] snap_req_r;
  logic [NUM_PORTS*KW_W-1:0] work_grant_r;
  logic [KW_W-1:0]           budget_r;
  logic                      clamp_r;

  logic [PW:0]               port_sum_s;
  logic [PW-1:0]             port_s;
  logic                      cur_valid_s;
  logic [KW_W-1:0]           cur_req_s;
  logic [KW_W-1:0]           grant_s;
  logic [KW_W-1:0]           budget_next_s;
  logic                      clamped_s;
  logic [NUM_PORTS*KW_W-1:0] next_grant_s;

  // Port visited this ALLOC cycle and the grant vector including its result
  always_comb begin
    port_sum_s = {1'b0, rr_ptr_r} + {1'b0, idx_r};
    if (port_sum_s >= PORT_NUM) begin
      port_s = PW'(port_sum_s - PORT_NUM);
    end else begin
      port_s = port_sum_s[PW-1:0];
    end
    cur_valid_s  = snap_valid_r[port_s];
    cur_req_s    = snap_req_r[int'(port_s)*KW_W +: KW_W];
    next_grant_s = work_grant_r;
    next_grant_s[int'(port_s)*KW_W +: KW_W] = grant_s;
  end

  greenflow_alloc_step #(.KW_W(KW_W)) u_step (
    .valid       (cur_valid_s),
    .req         (cur_req_s),
    .budget      (budget_r),
    .grant       (grant_s),
    .budget_next (budget_next_s),
    .clamped     (clamped_s)
  );

  // Scheduler FSM; grants are published on entry to COMMIT so an aborted
  // epoch never leaks partial results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= '0;
      rr_ptr_r       <= '0;
      idx_r          <= '0;
      snap_valid_r   <= '0;
      snap_req_r     <= '0;
      work_grant_r   <= '0;
      budget_r       <= '0;
      clamp_r        <= 1'b0;
      grant_kw       <= '0;
      budget_left_kw <= '0;
      grant_update   <= 1'b0;
      status_code    <= STAT_OFF;
    end else if ((state_r != ST_IDLE) && thermal_fault) begin
      state_r        <= ST_FAULT;
      cnt_r          <= '0;
      grant_kw       <= '0;
      budget_left_kw <= '0;
      status_code    <= STAT_THERMAL;
      grant_update   <= (state_r != ST_FAULT);
    end else if (!enable) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      grant_kw     <= '0;
      status_code  <= STAT_OFF;
      grant_update <= 1'b0;
    end else begin
      grant_update <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_WAIT;
          cnt_r   <= '0;
        end
        ST_WAIT: begin
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
            state_r <= ST_SNAP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_SNAP: begin
          snap_valid_r <= req_valid;
          snap_req_r   <= req_kw;
          budget_r     <= grid_limit_kw;
          work_grant_r <= '0;
          clamp_r      <= 1'b0;
          idx_r        <= '0;
          state_r      <= ST_ALLOC;
        end
        ST_ALLOC: begin
          work_grant_r <= next_grant_s;
          budget_r     <= budget_next_s;
          clamp_r      <= clamp_r | clamped_s;
          idx_r        <= idx_r + PW'(1);
          if (idx_r == PORT_LAST) begin
            state_r        <= ST_COMMIT;
            grant_kw       <= next_grant_s;
            budget_left_kw <= budget_next_s;
            grant_update   <= 1'b1;
            status_code    <= (clamp_r | clamped_s) ? STAT_CLAMP : STAT_OK;
            rr_ptr_r       <= (rr_ptr_r == PORT_LAST) ? '0 : rr_ptr_r + PW'(1);
          end else begin
            state_r <= ST_ALLOC;
          end
        end
        ST_COMMIT: begin
          cnt_r   <= '0;
          state_r <= ST_WAIT;
        end
        ST_FAULT: begin
          cnt_r   <= '0;
          state_r <= ST_WAIT;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_greenflow_power_scheduler.sv
// Self-checking bench: epoch-timeline model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_greenflow_power_scheduler;

  localparam int N = 4;
  localparam int W = 16;
  localparam int E = 8;
  localparam int M_OFF = 0;
  localparam int M_RUN = 1;
  localparam int M_FLT = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         thermal_fault = 1'b0;
  logic [W-1:0] grid_limit_kw = '0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_kw = '0;
  logic [N*W-1:0] grant_kw;
  logic           grant_update;
  logic [W-1:0]   budget_left_kw;
  logic [1:0]     status_code;

  int nvec = 0;
  int nfail = 0;

  greenflow_power_scheduler #(.NUM_PORTS(N), .KW_W(W), .EPOCH_CYCLES(E)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .grid_limit_kw  (grid_limit_kw),
    .thermal_fault  (thermal_fault),
    .req_valid      (req_valid),
    .req_kw         (req_kw),
    .grant_kw       (grant_kw),
    .grant_update   (grant_update),
    .budget_left_kw (budget_left_kw),
    .status_code    (status_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int a0, input int a1, input int a2, input int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  // Model: position in the epoch timeline (rc = cycles since WAIT began)
  int mode = M_OFF, rc = 0, rr = 0, sg = 0, eb = 0, es = 3, mb, mp;
  int sv[N], sr[N], eg[N];
  bit eu = 1'b0, mcl, started = 1'b0;
  logic [N*W-1:0] ev;

  always @(posedge clk) begin
    eu = 1'b0;
    if (rst) begin
      mode = M_OFF; rc = 0; rr = 0; sg = 0; eb = 0; es = 3;
      for (int p = 0; p < N; p++) begin eg[p] = 0; sv[p] = 0; sr[p] = 0; end
    end else if (mode != M_OFF && thermal_fault) begin
      if (mode != M_FLT) eu = 1'b1;
      mode = M_FLT; eb = 0; es = 2;
      for (int p = 0; p < N; p++) eg[p] = 0;
    end else if (!enable) begin
      mode = M_OFF; es = 3;
      for (int p = 0; p < N; p++) eg[p] = 0;
    end else if (mode != M_RUN) begin
      mode = M_RUN; rc = 0;
    end else begin
      if (rc == E) begin
        sg = int'(grid_limit_kw);
        for (int p = 0; p < N; p++) begin
          sv[p] = int'(req_valid[p]);
          sr[p] = int'(req_kw[p*W +: W]);
        end
      end
      if (rc == E + N) begin
        mb = sg; mcl = 1'b0;
        for (int k = 0; k < N; k++) begin
          mp = (rr + k) % N;
          if (sv[mp] != 0) begin
            eg[mp] = (sr[mp] < mb) ? sr[mp] : mb;
            mb -= eg[mp];
            if (eg[mp] < sr[mp]) mcl = 1'b1;
          end else begin
            eg[mp] = 0;
          end
        end
        eb = mb; es = mcl ? 1 : 0; eu = 1'b1; rr = (rr + 1) % N;
      end
      rc = (rc == E + N + 1) ? 0 : rc + 1;
    end
    started = 1'b1;
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      for (int p = 0; p < N; p++) ev[p*W +: W] = W'(eg[p]);
      chk("m_grant", grant_kw, ev);
      chk("m_budget", {48'd0, budget_left_kw}, {48'd0, W'(eb)});
      chk("m_status", {62'd0, status_code}, {62'd0, 2'(es)});
      chk("m_update", {63'd0, grant_update}, {63'd0, eu});
    end
  end

  task automatic setin(input int g, input logic [N-1:0] v, input int a0, input int a1,
                       input int a2, input int a3);
    grid_limit_kw = W'(g);
    req_valid     = v;
    req_kw        = pk(a0, a1, a2, a3);
  endtask

  task automatic wait_upd(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!grant_update && n < 60);
    chk("upd_timeout", {63'd0, grant_update}, {63'd0, 1'b1});
  endtask

  task automatic lit(input string nm, input logic [N*W-1:0] g, input int b, input int s);
    chk({nm, "_grant"}, grant_kw, g);
    chk({nm, "_budget"}, {48'd0, budget_left_kw}, {48'd0, W'(b)});
    chk({nm, "_status"}, {62'd0, status_code}, {62'd0, 2'(s)});
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit("reset", '0, 0, 3);
    chk("reset_upd", {63'd0, grant_update}, 64'd0);
    rst = 1'b0;

    // Even split, budget exactly consumed
    setin(200, 4'b1111, 50, 50, 50, 50);
    enable = 1'b1;
    wait_upd(n);
    chk("first_latency", 64'(n), 64'd14);
    lit("even", pk(50, 50, 50, 50), 0, 0);

    setin(500, 4'b1010, 0, 100, 0, 40);
    wait_upd(n);
    chk("epoch_period", 64'(n), 64'd14);
    lit("partial", pk(0, 100, 0, 40), 360, 0);

    // Round-robin fairness from rr_ptr=0 then 1
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    setin(200, 4'b0011, 150, 100, 0, 0);
    wait_upd(n);
    lit("rr0", pk(150, 50, 0, 0), 0, 1);
    wait_upd(n);
    lit("rr1", pk(100, 100, 0, 0), 0, 1);

    // Oversized single request, then zero grid
    setin(100, 4'b0001, 300, 0, 0, 0);
    wait_upd(n);
    lit("big", pk(100, 0, 0, 0), 0, 1);
    setin(0, 4'b0001, 300, 0, 0, 0);
    wait_upd(n);
    lit("zero_grid", '0, 0, 1);

    // Inputs wander every cycle; the model snapshots only at SNAP
    setin(400, 4'b1111, 10, 20, 30, 40);
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      req_kw[0 +: W] = W'((i * 37) % 250);
    end
    setin(200, 4'b1111, 50, 50, 50, 50);
    wait_upd(n);
    wait_upd(n);
    lit("stable", pk(50, 50, 50, 50), 0, 0);

    // Thermal fault in the 2nd ALLOC cycle
    repeat (11) @(posedge clk);
    @(negedge clk);
    thermal_fault = 1'b1;
    @(negedge clk);
    lit("thermal", '0, 0, 2);
    chk("thermal_upd", {63'd0, grant_update}, {63'd0, 1'b1});
    repeat (2) @(negedge clk);
    thermal_fault = 1'b0;
    wait_upd(n);
    chk("fault_release_lat", 64'(n), 64'd14);
    lit("post_fault", pk(50, 50, 50, 50), 0, 0);

    // Reset mid-ALLOC with enable held high
    setin(200, 4'b0011, 150, 100, 0, 0);
    repeat (11) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("mid_rst", '0, 0, 3);
    wait_upd(n);
    chk("rst_latency", 64'(n), 64'd14);
    lit("rst_rr0", pk(150, 50, 0, 0), 0, 1);

    // Enable dropped in WAIT, then re-enabled
    repeat (3) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("dis_grant", grant_kw, '0);
    chk("dis_status", {62'd0, status_code}, {62'd0, 2'b11});
    repeat (2) @(negedge clk);
    enable = 1'b1;
    wait_upd(n);
    chk("reen_latency", 64'(n), 64'd14);
    lit("reen", pk(100, 100, 0, 0), 0, 1);

    // Thermal wins over disable in the same cycle
    repeat (2) @(posedge clk);
    @(negedge clk);
    thermal_fault = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("prio_status", {62'd0, status_code}, {62'd0, 2'b10});
    thermal_fault = 1'b0;
    @(negedge clk);
    chk("prio_off", {62'd0, status_code}, {62'd0, 2'b11});
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
